// File: rtl/mpc_cost_argmin.sv
// mpc_cost_argmin
// Takes the signed weighted-error products from the MPC multiplier and turns
// them into a cost for each candidate switching vector. Each product is
// arithmetic-shifted right by SHIFT and rectified. TERMS products are summed
// per candidate, and the index of the cheapest candidate is reported once per
// control period.
//
// Optional feature (macro MPC_COST_SAT_EN):
//   defined     : cost additions saturate at 2^ACC_W-1 and set the sticky ovf
//   not defined : cost additions wrap modulo 2^ACC_W; ovf stays 0
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous reset, active low
//   ce         in   clock enable; low freezes every register
//   start      in   one-cycle pulse that starts or restarts a period
//   in_valid   in   in_data carries a product this cycle
//   in_data    in   signed product, PROD_W bits
//   in_ready   out  high while in RUN
//   busy       out  high from start until done
//   done       out  single enabled-cycle pulse; best_* valid
//   best_idx   out  index of the minimum-cost candidate
//   best_cost  out  cost of that candidate
//   ovf        out  sticky cost overflow for this period
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; best_* hold the last completed result
// RUN   | accepting products, one per cycle when in_valid=1
// DRAIN | last candidate is in the compare stage; publishes the result
module mpc_cost_argmin #(
   parameter int PROD_W   = 26,
   parameter int SHIFT    = 8,
   parameter int TERMS    = 2,
   parameter int NUM_CAND = 27,
   parameter int IDX_W    = 5,
   parameter int ACC_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce,
   input  logic              start,
   input  logic              in_valid,
   input  logic [PROD_W-1:0] in_data,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic [IDX_W-1:0]  best_idx,
   output logic [ACC_W-1:0]  best_cost,
   output logic              ovf
);

   localparam int T_W  = PROD_W - SHIFT;
   localparam int TC_W = (TERMS > 1) ? $clog2(TERMS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t            state_q, state_d;
   logic [TC_W-1:0]   term_cnt_q, term_cnt_d;
   logic [IDX_W-1:0]  cand_cnt_q, cand_cnt_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  cand_cost_q, cand_cost_d;
   logic              cand_vld_q, cand_vld_d;
   logic [IDX_W-1:0]  cand_idx_q, cand_idx_d;
   logic [ACC_W-1:0]  run_best_q, run_best_d;
   logic [IDX_W-1:0]  run_idx_q, run_idx_d;
   logic [IDX_W-1:0]  best_idx_q, best_idx_d;
   logic [ACC_W-1:0]  best_cost_q, best_cost_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;

   logic signed [PROD_W-1:0] din_s;
   logic signed [T_W-1:0]    t_s;
   logic [T_W-1:0]           mag;
   logic [ACC_W-1:0]         m;
   logic [ACC_W-1:0]         sum;
   logic                     sat;
   logic                     beat, last_term, last_cand;

   assign din_s = in_data;
   assign t_s   = T_W'(din_s >>> SHIFT);
   // Negating the most negative value in T_W bits yields 2^(T_W-1), which
   // reads correctly as an unsigned T_W-bit magnitude, so nothing wraps.
   assign mag   = t_s[T_W-1] ? (~t_s + T_W'(1)) : t_s;
   assign m     = ACC_W'(mag);

   // The candidate's final term and the running partial sum share one adder:
   // acc_q + m is either the new partial sum or the finished cost.
`ifdef MPC_COST_SAT_EN
   logic [ACC_W:0] sum_w;
   assign sum_w = {1'b0, acc_q} + {1'b0, m};
   assign sat   = sum_w[ACC_W];
   assign sum   = sat ? '1 : sum_w[ACC_W-1:0];
`else
   assign sum = acc_q + m;
   assign sat = 1'b0;
`endif

   assign beat      = (state_q == S_RUN) && in_valid;
   assign last_term = (term_cnt_q == TC_W'(TERMS - 1));
   assign last_cand = (cand_cnt_q == IDX_W'(NUM_CAND - 1));

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  state_q <= S_IDLE;
      else if (ce) state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN: begin
            if (start)                               state_d = S_RUN;
            else if (beat && last_term && last_cand) state_d = S_DRAIN;
         end
         S_DRAIN: state_d = start ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready = (state_q == S_RUN);
      busy     = (state_q != S_IDLE);
   end

   // Datapath next-state
   always_comb begin
      term_cnt_d  = term_cnt_q;
      cand_cnt_d  = cand_cnt_q;
      acc_d       = acc_q;
      cand_cost_d = cand_cost_q;
      cand_vld_d  = 1'b0;
      cand_idx_d  = cand_idx_q;
      run_best_d  = run_best_q;
      run_idx_d   = run_idx_q;
      best_idx_d  = best_idx_q;
      best_cost_d = best_cost_q;
      done_d      = 1'b0;
      ovf_d       = ovf_q;

      // Strict compare: on a tie the earlier (lower) index is kept.
      if (cand_vld_q && (cand_cost_q < run_best_q)) begin
         run_best_d = cand_cost_q;
         run_idx_d  = cand_idx_q;
      end

      if (start) begin
         // A restart also drops any candidate still in the compare stage.
         term_cnt_d = '0;
         cand_cnt_d = '0;
         acc_d      = '0;
         ovf_d      = 1'b0;
         run_best_d = '1;
         run_idx_d  = '0;
      end else begin
         if (beat) begin
            if (sat) ovf_d = 1'b1;
            if (last_term) begin
               cand_cost_d = sum;
               cand_vld_d  = 1'b1;
               cand_idx_d  = cand_cnt_q;
               acc_d       = '0;
               term_cnt_d  = '0;
               cand_cnt_d  = cand_cnt_q + IDX_W'(1);
            end else begin
               acc_d      = sum;
               term_cnt_d = term_cnt_q + TC_W'(1);
            end
         end
         // DRAIN publishes the compare result of this same cycle, which
         // lets done appear two cycles after the final beat.
         if (state_q == S_DRAIN) begin
            best_idx_d  = run_idx_d;
            best_cost_d = run_best_d;
            done_d      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         term_cnt_q  <= '0;
         cand_cnt_q  <= '0;
         acc_q       <= '0;
         cand_cost_q <= '0;
         cand_vld_q  <= 1'b0;
         cand_idx_q  <= '0;
         run_best_q  <= '1;
         run_idx_q   <= '0;
         best_idx_q  <= '0;
         best_cost_q <= '0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (ce) begin
         term_cnt_q  <= term_cnt_d;
         cand_cnt_q  <= cand_cnt_d;
         acc_q       <= acc_d;
         cand_cost_q <= cand_cost_d;
         cand_vld_q  <= cand_vld_d;
         cand_idx_q  <= cand_idx_d;
         run_best_q  <= run_best_d;
         run_idx_q   <= run_idx_d;
         best_idx_q  <= best_idx_d;
         best_cost_q <= best_cost_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
      end
   end

   assign done      = done_q;
   assign best_idx  = best_idx_q;
   assign best_cost = best_cost_q;
   assign ovf       = ovf_q;

endmodule
